softproc_onchip_memory_dp: RTL and testbench
============================================

# softproc_onchip_memory_dp

Parametrised dual-port on-chip RAM for the softproc system, with two independent Avalon-MM slave ports (s1, s2) sharing one storage array. It generalises the single-port 32x4096 memory with configurable width, depth and read latency, and adds readdatavalid/waitrequest handshakes. It also defines a fixed rule for same-address collisions between the ports and an optional hardware scrub-to-zero after reset. It sits on the system interconnect; typically s1 serves instruction fetch and s2 serves data.

## Interface
- DATA_WIDTH, 32: word width; multiple of 8.
- ADDR_WIDTH, 12: word address width; depth = 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from read accept to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting transfers.
- INIT_FILE, "softproc_onchip_memory_dp.hex": power-up contents; ignored for words overwritten by the clear.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- clken  in  1  global clock enable.
- reset_req  in  1  high = stall all activity, as if clken were low.
- sN_address  in  ADDR_WIDTH  word address (N = 1, 2).
- sN_chipselect  in  1  port select.
- sN_read  in  1  read request.
- sN_write  in  1  write request.
- sN_byteenable  in  DATA_WIDTH/8  byte lanes for writes.
- sN_writedata  in  DATA_WIDTH  write data.
- sN_readdata  out  DATA_WIDTH  read data; valid when sN_readdatavalid is high.
- sN_readdatavalid  out  1  one-cycle pulse per accepted read.
- sN_waitrequest  out  1  high = request not accepted this cycle.

## Operation
- en = clken & ~reset_req.
- FSM states: CLEAR and RUN.
  - reset forces CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - In CLEAR, a counter writes zero to words 0..depth-1, one word per en cycle.
  - The transition CLEAR to RUN follows the cycle that writes word depth-1.
  - The counter holds while en is low.
- sN_waitrequest = reset | (state==CLEAR) | ~en.
- Accept condition for port N: sN_chipselect & (sN_read | sN_write) & ~sN_waitrequest.
- Accepted write: each lane with its byteenable bit set is updated. Byteenable all-zero leaves the word unchanged.
- read and write asserted together: treated as a write only; no readdatavalid is generated.
- Write-write collision (both ports write the same address in the same cycle):
  - For each lane, s1 wins where s1's byteenable is set.
  - s2's data is written only in lanes enabled by s2 alone.
- Read-write collision across ports (same address, same cycle): the read returns the old, pre-write data.
- Different addresses: both ports are fully independent, each with one transfer per cycle.
- Read pipeline: a per-port valid/data shift of depth READ_LATENCY. The pipeline advances only on en cycles.
- Reset mid-operation: read pipelines are flushed and in-flight reads are dropped.
  - Memory contents are not otherwise altered, except by the CLEAR scrub when CLEAR_ON_RESET=1.
  - An in-progress CLEAR restarts from word 0.

## Timing
- Reset values: sN_readdata = 0, sN_readdatavalid = 0, sN_waitrequest = 1.
- Clear duration: exactly depth en-cycles after reset deasserts.
  - The first cycle with sN_waitrequest low is cycle depth+1 after reset release when en is held high.
  - With CLEAR_ON_RESET=0, sN_waitrequest goes low on the first cycle after reset release.
- Read latency: a read accepted at edge k gives sN_readdatavalid high and sN_readdata valid after edge k+READ_LATENCY, counting en edges only.
- sN_readdatavalid is forced low in any cycle where en is low. The pending beat is presented on the next en cycle.
- sN_readdata holds its last value when sN_readdatavalid is low.
- Write data is visible to a read on either port accepted at edge k+1 or later.
- Throughput: one read or write per port per cycle, with no bubbles between back-to-back transfers.

## Test plan
- Clear: CLEAR_ON_RESET=1, ADDR_WIDTH=4, INIT_FILE filled with 0xFFFFFFFF, reset for 1 cycle -> waitrequest high for 16 cycles; then reads of words 0..15 return 0x00000000.
- Latency: READ_LATENCY=2, write 0xDEADBEEF at 0x005 via s1, then read 0x005 via s2 on the next cycle -> s2_readdatavalid high 2 cycles after accept with 0xDEADBEEF; exactly one pulse.
- Byte lanes: word at 0x010 holds 0x11223344; s1 writes 0xAABBCCDD with byteenable 0b0101 -> readback 0x11BB33DD.
- Collision: word at 0x020 holds 0; in the same cycle s1 writes 0x000000FF with byteenable 0b0001 and s2 writes 0xFFFFFF00 with byteenable 0b1111 -> word = 0xFFFFFFFF. A simultaneous s2 read of 0x030 while s1 writes 0x030 with 0x12345678 (old value 0x0) -> s2 reads 0x0; a later read returns 0x12345678.
- Stall: drop clken for 3 cycles while a READ_LATENCY=1 read is in flight -> waitrequest high and readdatavalid low for those 3 cycles; the data beat appears on the first cycle after clken returns. Repeat the test using reset_req instead of clken.
- Reset mid-clear and mid-read: assert reset at clear count 7 -> the clear restarts and lasts the full depth. Assert reset one cycle after a read is accepted -> no readdatavalid pulse is ever produced.

Source files
------------

// File: rtl/softproc_onchip_memory_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slave ports sharing one array.
// Includes a post-reset scrub to zero, fixed collision rules and a per-port read pipeline.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | scrubbing words 0..depth-1 to zero, both ports held off
// ST_RUN   | normal operation, each port accepts one transfer per cycle

module softproc_onchip_memory_dp #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter     INIT_FILE      = "softproc_onchip_memory_dp.hex"
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clken,
   input  logic                    reset_req,

   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,
   output logic                    s1_waitrequest,

   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic                    s2_chipselect,
   input  logic                    s2_read,
   input  logic                    s2_write,
   input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
   input  logic [DATA_WIDTH-1:0]   s2_writedata,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,
   output logic                    s2_waitrequest
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / 8;

   // Power-up contents are attached by the device build flow under this name.
   if ($bits(INIT_FILE) > 0) begin : g_init_file
   end

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clear_cnt_q, clear_cnt_d;
   logic                    clear_we;

   logic                    en;
   logic                    wait_all;

   logic [ADDR_WIDTH-1:0]   p_addr  [2];
   logic [NB-1:0]           p_be    [2];
   logic [DATA_WIDTH-1:0]   p_wdata [2];
   logic [1:0]              acc_rd;
   logic [1:0]              acc_wr;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    rv_q   [2][READ_LATENCY];
   logic                    rv_d   [2][READ_LATENCY];
   logic [DATA_WIDTH-1:0]   rd_q   [2][READ_LATENCY];
   logic [DATA_WIDTH-1:0]   rd_d   [2][READ_LATENCY];
   logic [DATA_WIDTH-1:0]   hold_q [2];
   logic [DATA_WIDTH-1:0]   hold_d [2];
   logic [1:0]              out_v;
   logic [DATA_WIDTH-1:0]   out_d  [2];

   assign en       = clken & ~reset_req;
   assign wait_all = reset | (state_q == ST_CLEAR) | ~en;

   assign p_addr[0]  = s1_address;
   assign p_addr[1]  = s2_address;
   assign p_be[0]    = s1_byteenable;
   assign p_be[1]    = s2_byteenable;
   assign p_wdata[0] = s1_writedata;
   assign p_wdata[1] = s2_writedata;

   // A request with both read and write set is a plain write.
   assign acc_wr[0] = s1_chipselect & s1_write & ~wait_all;
   assign acc_wr[1] = s2_chipselect & s2_write & ~wait_all;
   assign acc_rd[0] = s1_chipselect & s1_read & ~s1_write & ~wait_all;
   assign acc_rd[1] = s2_chipselect & s2_read & ~s2_write & ~wait_all;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clear_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         clear_cnt_q <= clear_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clear_cnt_d = clear_cnt_q;
      clear_we    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            if (en && !reset) begin
               clear_we    = 1'b1;
               clear_cnt_d = clear_cnt_q + 1'b1;
               if (&clear_cnt_q) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // s2 lanes are written first so that s1 overrides any lane both ports enable.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem_q[clear_cnt_q] <= '0;
      end
      for (int p = 1; p >= 0; p--) begin
         if (acc_wr[p]) begin
            for (int b = 0; b < NB; b++) begin
               if (p_be[p][b]) begin
                  mem_q[p_addr[p]][b*8 +: 8] <= p_wdata[p][b*8 +: 8];
               end
            end
         end
      end
   end

   // Reads sample the array before this edge's writes land, so a same-address
   // read returns the old word.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            rv_d[p][i] = rv_q[p][i];
            rd_d[p][i] = rd_q[p][i];
         end
         if (en) begin
            rv_d[p][0] = acc_rd[p];
            if (acc_rd[p]) begin
               rd_d[p][0] = mem_q[p_addr[p]];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
               rv_d[p][i] = rv_q[p][i-1];
               rd_d[p][i] = rd_q[p][i-1];
            end
         end
         out_v[p]  = rv_q[p][READ_LATENCY-1] & en & ~reset;
         out_d[p]  = out_v[p] ? rd_q[p][READ_LATENCY-1] : hold_q[p];
         hold_d[p] = out_d[p];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
               rv_q[p][i] <= 1'b0;
               rd_q[p][i] <= '0;
            end
            hold_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
               rv_q[p][i] <= rv_d[p][i];
               rd_q[p][i] <= rd_d[p][i];
            end
            hold_q[p] <= hold_d[p];
         end
      end
   end

   assign s1_readdata      = out_d[0];
   assign s2_readdata      = out_d[1];
   assign s1_readdatavalid = out_v[0];
   assign s2_readdatavalid = out_v[1];
   assign s1_waitrequest   = wait_all;
   assign s2_waitrequest   = wait_all;

endmodule

// File: tb/tb_softproc_onchip_memory_dp.sv
// Bench for softproc_onchip_memory_dp: directed scenarios plus random traffic,
// every cycle compared against a word-array / read-queue reference model.

module tb_softproc_onchip_memory_dp;

   localparam int DW    = 32;
   localparam int AW    = 6;
   localparam int RL    = 2;
   localparam int DEPTH = 2 ** AW;
   localparam int NB    = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, clken, reset_req;
   logic [AW-1:0] addr    [2];
   logic          cs      [2];
   logic          rd      [2];
   logic          wr      [2];
   logic [NB-1:0] be      [2];
   logic [DW-1:0] wd      [2];
   logic [DW-1:0] rdata   [2];
   logic          rvalid  [2];
   logic          waitreq [2];

   softproc_onchip_memory_dp #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .READ_LATENCY   (RL),
      .CLEAR_ON_RESET (1'b1),
      .INIT_FILE      ("softproc_onchip_memory_dp.hex")
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .clken            (clken),
      .reset_req        (reset_req),
      .s1_address       (addr[0]),
      .s1_chipselect    (cs[0]),
      .s1_read          (rd[0]),
      .s1_write         (wr[0]),
      .s1_byteenable    (be[0]),
      .s1_writedata     (wd[0]),
      .s1_readdata      (rdata[0]),
      .s1_readdatavalid (rvalid[0]),
      .s1_waitrequest   (waitreq[0]),
      .s2_address       (addr[1]),
      .s2_chipselect    (cs[1]),
      .s2_read          (rd[1]),
      .s2_write         (wr[1]),
      .s2_byteenable    (be[1]),
      .s2_writedata     (wd[1]),
      .s2_readdata      (rdata[1]),
      .s2_readdatavalid (rvalid[1]),
      .s2_waitrequest   (waitreq[1])
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // reference model
   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } beat_t;

   logic [DW-1:0] mem_m [DEPTH];
   beat_t         q0 [$];
   beat_t         q1 [$];
   logic [DW-1:0] last_m [2];
   logic          clearing;
   int            clr_pos;
   int            en_edges;

   logic          obs_v [2];
   logic [DW-1:0] obs_d [2];
   logic          obs_w;

   function automatic int qsize(input int p);
      if (p == 0) return q0.size();
      return q1.size();
   endfunction

   function automatic beat_t qhead(input int p);
      if (p == 0) return q0[0];
      return q1[0];
   endfunction

   task automatic qpop(input int p);
      if (p == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic qpush(input int p, input logic [DW-1:0] d, input int due);
      beat_t b;
      b.data = d;
      b.due  = due;
      if (p == 0) q0.push_back(b);
      else        q1.push_back(b);
   endtask

   // Compare this cycle's outputs, then advance the model across the coming edge.
   task automatic step();
      logic          en_m;
      logic          vis [2];
      logic [DW-1:0] exp_d;
      beat_t         b;
      @(negedge clk);
      en_m = clken & ~reset_req;
      for (int p = 0; p < 2; p++) begin
         vis[p] = 1'b0;
         exp_d  = last_m[p];
         if (en_m && !reset && qsize(p) > 0) begin
            b = qhead(p);
            if (b.due <= en_edges) begin
               vis[p] = 1'b1;
               exp_d  = b.data;
            end
         end
         chk($sformatf("s%0d_waitrequest", p + 1), {31'b0, waitreq[p]},
             {31'b0, reset | clearing | ~en_m});
         chk($sformatf("s%0d_readdatavalid", p + 1), {31'b0, rvalid[p]}, {31'b0, vis[p]});
         chk($sformatf("s%0d_readdata", p + 1), rdata[p], exp_d);
         obs_v[p] = rvalid[p];
         obs_d[p] = rdata[p];
      end
      obs_w = waitreq[0];

      if (reset) begin
         clearing = 1'b1;
         clr_pos  = 0;
         q0.delete();
         q1.delete();
         last_m[0] = '0;
         last_m[1] = '0;
      end else if (en_m) begin
         for (int p = 0; p < 2; p++) begin
            if (vis[p]) begin
               last_m[p] = qhead(p).data;
               qpop(p);
            end
         end
         en_edges++;
         if (clearing) begin
            mem_m[clr_pos] = '0;
            clr_pos++;
            if (clr_pos == DEPTH) clearing = 1'b0;
         end else begin
            for (int p = 0; p < 2; p++) begin
               if (cs[p] && rd[p] && !wr[p]) qpush(p, mem_m[addr[p]], en_edges + RL - 1);
            end
            for (int b2 = 0; b2 < NB; b2++) begin
               if (cs[0] && wr[0] && be[0][b2])
                  mem_m[addr[0]][8*b2 +: 8] = wd[0][8*b2 +: 8];
               if (cs[1] && wr[1] && be[1][b2] &&
                   !(cs[0] && wr[0] && be[0][b2] && addr[0] == addr[1]))
                  mem_m[addr[1]][8*b2 +: 8] = wd[1][8*b2 +: 8];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int p = 0; p < 2; p++) begin
         cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
         addr[p] = '0; be[p] = '0; wd[p] = '0;
      end
   endtask

   task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [NB-1:0] e);
      cs[p] = 1'b1; wr[p] = 1'b1; rd[p] = 1'b0; addr[p] = a; wd[p] = d; be[p] = e;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0; addr[p] = a;
   endtask

   task automatic read_back(input int p, input logic [AW-1:0] a,
                            output logic [DW-1:0] d, output logic seen);
      idle();
      set_rd(p, a);
      step();
      idle();
      seen = 1'b0;
      d    = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (obs_v[p] && !seen) begin
            seen = 1'b1;
            d    = obs_d[p];
         end
      end
   endtask

   task automatic count_clear(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (obs_w) n++;
         else break;
      end
   endtask

   initial begin
      int            n;
      int            first;
      int            pulses;
      int            wcnt;
      logic [DW-1:0] d;
      logic          seen;

      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      last_m[0] = '0;
      last_m[1] = '0;
      clearing  = 1'b1;
      clr_pos   = 0;
      en_edges  = 0;

      idle();
      clken     = 1'b1;
      reset_req = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      step();
      reset = 1'b0;
      count_clear(n);
      chk("clear_length", n, DEPTH);

      // latency: write via s1, read same word via s2 on the next cycle
      set_wr(0, 6'h05, 32'hDEADBEEF, 4'hF);
      step();
      idle();
      set_rd(1, 6'h05);
      step();
      idle();
      first  = 0;
      pulses = 0;
      d      = '0;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (obs_v[1]) begin
            pulses++;
            if (first == 0) begin
               first = i;
               d     = obs_d[1];
            end
         end
      end
      chk("latency_cycles", first, RL);
      chk("latency_data", d, 32'hDEADBEEF);
      chk("latency_pulses", pulses, 1);

      // byte lanes
      set_wr(0, 6'h10, 32'h11223344, 4'hF);
      step();
      set_wr(0, 6'h10, 32'hAABBCCDD, 4'b0101);
      step();
      read_back(0, 6'h10, d, seen);
      chk("lanes_seen", {31'b0, seen}, 32'd1);
      chk("lanes_data", d, 32'h11BB33DD);

      // write-write collision
      idle();
      set_wr(0, 6'h20, 32'h000000FF, 4'b0001);
      set_wr(1, 6'h20, 32'hFFFFFF00, 4'b1111);
      step();
      read_back(1, 6'h20, d, seen);
      chk("ww_collision", d, 32'hFFFFFFFF);

      // read-write collision returns old data
      idle();
      set_wr(0, 6'h30, 32'h12345678, 4'hF);
      set_rd(1, 6'h30);
      step();
      idle();
      seen = 1'b0;
      d    = 32'hFFFFFFFF;
      for (int i = 0; i < 6; i++) begin
         step();
         if (obs_v[1] && !seen) begin
            seen = 1'b1;
            d    = obs_d[1];
         end
      end
      chk("rw_old_seen", {31'b0, seen}, 32'd1);
      chk("rw_old_data", d, 32'h0);
      read_back(0, 6'h30, d, seen);
      chk("rw_new_data", d, 32'h12345678);

      // stall with clken, then with reset_req
      for (int k = 0; k < 2; k++) begin
         idle();
         set_rd(0, 6'h05);
         step();
         idle();
         step();
         if (k == 0) clken = 1'b0;
         else        reset_req = 1'b1;
         wcnt   = 0;
         pulses = 0;
         for (int i = 0; i < 3; i++) begin
            step();
            if (obs_w) wcnt++;
            if (obs_v[0]) pulses++;
         end
         chk($sformatf("stall%0d_wait", k), wcnt, 3);
         chk($sformatf("stall%0d_novalid", k), pulses, 0);
         clken     = 1'b1;
         reset_req = 1'b0;
         step();
         chk($sformatf("stall%0d_beat", k), {31'b0, obs_v[0]}, 32'd1);
         chk($sformatf("stall%0d_data", k), obs_d[0], 32'hDEADBEEF);
         idle();
         step();
      end

      // reset one cycle after an accepted read drops the beat
      set_rd(1, 6'h07);
      step();
      idle();
      reset = 1'b1;
      step();
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < DEPTH + 8; i++) begin
         step();
         if (obs_v[1]) pulses++;
      end
      chk("reset_drop_read", pulses, 0);

      // reset mid-clear restarts the scrub
      set_wr(0, 6'h03, 32'hCAFEF00D, 4'hF);
      step();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 7; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      count_clear(n);
      chk("clear_restart_length", n, DEPTH);
      for (int a = 0; a < 16; a++) begin
         read_back(a % 2, AW'(a), d, seen);
         chk($sformatf("scrub_word_%0d", a), d, 32'h0);
      end

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 499) == 0);
         clken     = ($urandom_range(0, 7) != 0);
         reset_req = ($urandom_range(0, 15) == 0);
         for (int p = 0; p < 2; p++) begin
            cs[p]   = ($urandom_range(0, 3) != 0);
            rd[p]   = ($urandom_range(0, 1) == 1);
            wr[p]   = ($urandom_range(0, 2) == 0);
            addr[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                  : AW'($urandom_range(0, 3));
            be[p]   = NB'($urandom);
            wd[p]   = $urandom;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
